param_proc_core: RTL and testbench

//  Parametrised multicycle processor core; successor of the 16-bit enhanced processor.

---
 rtl/proc_pkg.sv | 62 ++++++
 rtl/proc_alu.sv | 54 +++++
 rtl/param_proc_core.sv | 162 ++++++++++++++++
 tb/tb_param_proc_core.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multicycle processor core.
// Latency: none (definitions only).
// Backpressure: n/a.
// Contents: opcodes, branch condition codes, FSM states, ALU selects, flag bit
// positions, and the branch-condition helper.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_B   = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CC = 3'd3;
  localparam logic [2:0] COND_CS = 3'd4;
  localparam logic [2:0] COND_PL = 3'd5;
  localparam logic [2:0] COND_MI = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  // Bit positions inside the {c,n,z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND
  } alu_op_t;

  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
    logic r;
    r = 1'b0;
    case (cond)
      COND_AL: r = 1'b1;
      COND_EQ: r = flags[FLAG_Z];
      COND_NE: r = !flags[FLAG_Z];
      COND_CC: r = !flags[FLAG_C];
      COND_CS: r = flags[FLAG_C];
      COND_PL: r = !flags[FLAG_N];
      COND_MI: r = flags[FLAG_N];
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational add/sub/and unit producing result and {c,n,z} flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: op (ALU select), a/b operands, res result, flags {c,n,z}.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic [2:0]        flags
);

  logic [DATA_W:0] sum;
  logic            carry;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      ALU_SUB: begin
        // a + ~b + 1: carry-out is the not-borrow flag.
        sum   = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      ALU_AND: begin
        res   = a & b;
        carry = 1'b0;
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[DATA_W-1];
    flags[FLAG_C] = carry;
  end

endmodule

// File: rtl/param_proc_core.sv
// Multicycle processor core: 8 x DATA_W registers (R7 = PC), external memory via req/ack.
// Latency: zero-wait memory gives 2 cycles for mv/alu/b and 3 for ld/st; each wait state adds 1.
// Backpressure: mem_req and its address/data/we are held until mem_ack; no other stalls.
// Ports: clk_50MHz, reset_n (sync, active-low), run; mem_req/we/addr/wdata out, mem_ack/rdata in;
//        done (retire pulse), halted, pc_out (R7), flags_out {c,n,z}.
// Build option PROC_BUS_TIMEOUT_EN: watchdog on outstanding requests, HALT on expiry.
module param_proc_core
  import proc_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 8,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              halted,
  output logic [DATA_W-1:0] pc_out,
  output logic [2:0]        flags_out
);

  state_t            state, state_d;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [2:0]        flags;
  logic              done_q;
  logic              retire;
  logic              bus_timeout;

  logic [2:0]        op, rx, ry;
  logic              m;
  logic [8:0]        imm9;
  logic [DATA_W-1:0] rx_val, ry_val, op2, br_off, alu_res;
  logic [2:0]        alu_flags;
  alu_op_t           alu_op;

  assign op     = ir[15:13];
  assign m      = ir[12];
  assign rx     = ir[11:9];
  assign imm9   = ir[8:0];
  assign ry     = ir[2:0];
  assign rx_val = regs[rx];
  assign ry_val = regs[ry];
  assign op2    = m ? {{(DATA_W-9){1'b0}}, imm9} : ry_val;
  assign br_off = {{(DATA_W-9){imm9[8]}}, imm9};
  assign alu_op = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND : ALU_SUB;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (alu_op),
    .a     (rx_val),
    .b     (op2),
    .res   (alu_res),
    .flags (alu_flags)
  );

  // Bus outputs decode straight from the state register, so they stay
  // stable for the whole transaction and drop on the reset edge.
  assign mem_req   = (state == ST_FETCH) || (state == ST_MEM);
  assign mem_we    = (state == ST_MEM) && (op == OP_ST);
  assign mem_addr  = (state == ST_MEM) ? ry_val[ADDR_W-1:0] : regs[7][ADDR_W-1:0];
  assign mem_wdata = rx_val;

  assign done      = done_q;
  assign pc_out    = regs[7];
  assign flags_out = flags;

`ifdef PROC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  // Counts request cycles without ack; any idle cycle or ack restarts it,
  // so each new transaction gets the full TIMEOUT_CYC window.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n || !mem_req || mem_ack) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + CNT_W'(1);
  end

  assign bus_timeout = mem_req && !mem_ack && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign halted      = (state == ST_HALT);
`else
  assign bus_timeout = 1'b0;
  assign halted      = 1'b0;
`endif

  always_comb begin
    state_d = state;
    retire  = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)          state_d = ST_EXEC;
        else if (bus_timeout) state_d = ST_HALT;
      end
      ST_EXEC: begin
        if (op == OP_LD || op == OP_ST) begin
          state_d = ST_MEM;
        end else begin
          retire  = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end else if (bus_timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      ir     <= '0;
      flags  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7] <= RESET_PC;
    end else begin
      state  <= state_d;
      done_q <= retire;
      case (state)
        ST_FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata[15:0];
            regs[7] <= regs[7] + DATA_W'(1);
          end
        end
        ST_EXEC: begin
          // R7 already points past this instruction; a write to R7 here is a jump.
          case (op)
            OP_MV: regs[rx] <= op2;
            OP_B:  if (cond_true(rx, flags)) regs[7] <= regs[7] + br_off;
            OP_ADD, OP_SUB, OP_AND: begin
              regs[rx] <= alu_res;
              flags    <= alu_flags;
            end
            OP_CMP: flags <= alu_flags;
            default: ;
          endcase
        end
        ST_MEM: begin
          if (mem_ack && op == OP_LD) regs[rx] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_proc_core.sv
// Self-checking bench for param_proc_core with a wait-state memory model
// and a retire scoreboard (expected pc/flags/register/latency per done pulse).
module tb_param_proc_core;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 20;

  logic          clk_50MHz = 1'b0;
  logic          reset_n   = 1'b0;
  logic          run       = 1'b0;
  logic          mem_ack   = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_req, mem_we, done, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pc_out;
  logic [2:0]    flags_out;

  param_proc_core #(
    .DATA_W(DW), .ADDR_W(AW), .RESET_PC(16'h0000), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (done),
    .halted    (halted),
    .pc_out    (pc_out),
    .flags_out (flags_out)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    int          id;
    logic [15:0] pc;
    logic [2:0]  fl;
    int          ridx;
    logic [15:0] rval;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_done = 0;
  int          n_done = 0;
  int          st_cyc = 0;
  int          st_ok  = 0;
  int          wcnt   = 0;
  int          wait_st = 0;
  logic        ack_hold = 1'b0;
  logic [15:0] mem  [256];
  logic [15:0] smem [256];
  logic        sval [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic m,
                                      input logic [2:0] rx, input logic [8:0] imm);
    return {op, m, rx, imm};
  endfunction

  task automatic push(input int id, input int pc, input logic [2:0] fl,
                      input int ridx, input int rval, input int gap);
    exp_t x;
    x.id = id; x.pc = 16'(pc); x.fl = fl; x.ridx = ridx; x.rval = 16'(rval); x.gap = gap;
    sb.push_back(x);
  endtask

  always @(posedge clk_50MHz) cyc++;

  // Memory model: ack after wait_st extra request cycles, one-cycle pulse.
  always @(negedge clk_50MHz) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (mem_req && !ack_hold) begin
      if (wcnt >= wait_st) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          smem[mem_addr] = mem_wdata;
          sval[mem_addr] = 1'b1;
        end else begin
          mem_rdata = sval[mem_addr] ? smem[mem_addr] : mem[mem_addr];
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Store-bus observer: cycles with a write request, and those carrying the expected address/data.
  always @(negedge clk_50MHz) begin
    if (reset_n && mem_req && mem_we) begin
      st_cyc++;
      if (mem_addr == 8'h10 && mem_wdata == 16'h00A5) st_ok++;
    end
  end

  // Retire scoreboard.
  always @(negedge clk_50MHz) begin
    if (reset_n && done) begin
      n_done++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("i%0d_pc", e.id), 32'(pc_out), 32'(e.pc));
        chk($sformatf("i%0d_flags", e.id), 32'(flags_out), 32'(e.fl));
        if (e.ridx >= 0) chk($sformatf("i%0d_r%0d", e.id, e.ridx), 32'(dut.regs[e.ridx]), 32'(e.rval));
        if (e.gap > 0) chk($sformatf("i%0d_gap", e.id), 32'(cyc - last_done), 32'(e.gap));
      end
      last_done = cyc;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    ack_hold = 1'b0;
    repeat (2) @(negedge clk_50MHz);
    reset_n = 1'b1;
    @(negedge clk_50MHz);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, cnt, d0, s0, s1;
    for (int i = 0; i < 256; i++) begin smem[i] = 16'h0; sval[i] = 1'b0; end
    clear_mem();

    // Reset state
    do_reset();
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_flags", 32'(flags_out), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // mv/add, then mv r7 acting as a jump
    wait_st = 0;
    clear_mem();
    mem[0] = enc(3'b000, 1'b1, 3'd0, 9'd5);
    mem[1] = enc(3'b010, 1'b1, 3'd0, 9'd3);
    mem[2] = enc(3'b000, 1'b1, 3'd7, 9'd6);
    mem[6] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
    push(10, 1, 3'b000, 0, 5, 0);
    push(11, 2, 3'b000, 0, 8, 2);
    push(12, 6, 3'b000, 7, 6, 2);
    push(13, 6, 3'b000, -1, 0, 2);
    run = 1'b1;
    drain("t1_drain", 200);
    do_reset();

    // sub r1,r1 ; beq -2 loop
    clear_mem();
    mem[0] = enc(3'b011, 1'b0, 3'd1, 9'd1);
    mem[1] = enc(3'b001, 1'b0, 3'd1, 9'h1FE);
    push(20, 1, 3'b101, 1, 0, 0);
    push(21, 0, 3'b101, -1, 0, 2);
    push(22, 1, 3'b101, 1, 0, 2);
    push(23, 0, 3'b101, -1, 0, 2);
    run = 1'b1;
    drain("t2_drain", 200);
    do_reset();

    // r1=1, cmp r1,#1 ; bne -2 not taken
    clear_mem();
    mem[0] = enc(3'b000, 1'b1, 3'd1, 9'd1);
    mem[1] = enc(3'b111, 1'b1, 3'd1, 9'd1);
    mem[2] = enc(3'b001, 1'b0, 3'd2, 9'h1FE);
    mem[3] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
    push(30, 1, 3'b000, 1, 1, 0);
    push(31, 2, 3'b101, 1, 1, 2);
    push(32, 3, 3'b101, -1, 0, 2);
    push(33, 3, 3'b101, -1, 0, 2);
    run = 1'b1;
    drain("t3_drain", 200);
    do_reset();

    // Wrap-around and flag variety
    clear_mem();
    mem[0] = enc(3'b000, 1'b1, 3'd0, 9'd0);
    mem[1] = enc(3'b011, 1'b1, 3'd0, 9'd1);
    mem[2] = enc(3'b010, 1'b1, 3'd0, 9'd2);
    mem[3] = enc(3'b110, 1'b1, 3'd0, 9'h1F0);
    mem[4] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
    push(40, 1, 3'b000, 0, 0, 0);
    push(41, 2, 3'b010, 0, 16'hFFFF, 2);
    push(42, 3, 3'b100, 0, 1, 2);
    push(43, 4, 3'b001, 0, 0, 2);
    push(44, 4, 3'b001, -1, 0, 2);
    run = 1'b1;
    drain("t4_drain", 200);

    // Reset while a fetch is waiting for ack
    ack_hold = 1'b1;
    repeat (4) @(negedge clk_50MHz);
    chk("wait_req", 32'(mem_req), 32'h1);
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge clk_50MHz);
    chk("rstw_req", 32'(mem_req), 32'h0);
    chk("rstw_pc", 32'(pc_out), 32'h0);
    chk("rstw_flags", 32'(flags_out), 32'h0);
    chk("rstw_done", 32'(done), 32'h0);
    chk("rstw_r0", 32'(dut.regs[0]), 32'h0);
    ack_hold = 1'b0;
    reset_n  = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    chk("rstw_idle_req", 32'(mem_req), 32'h0);
    chk("rstw_idle_pc", 32'(pc_out), 32'h0);
    do_reset();

    // st/ld with 3 wait states
    wait_st = 3;
    clear_mem();
    mem[0] = enc(3'b000, 1'b1, 3'd2, 9'h0A5);
    mem[1] = enc(3'b000, 1'b1, 3'd3, 9'h010);
    mem[2] = enc(3'b101, 1'b0, 3'd2, 9'd3);
    mem[3] = enc(3'b100, 1'b0, 3'd4, 9'd3);
    mem[4] = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
    push(50, 1, 3'b000, 2, 16'h00A5, 0);
    push(51, 2, 3'b000, 3, 16'h0010, 5);
    push(52, 3, 3'b000, -1, 0, 9);
    push(53, 4, 3'b000, 4, 16'h00A5, 9);
    push(54, 4, 3'b000, -1, 0, 5);
    s0 = st_cyc;
    s1 = st_ok;
    run = 1'b1;
    drain("t5_drain", 300);
    chk("st_hold_cyc", 32'(st_cyc - s0), 32'd4);
    chk("st_hold_ok", 32'(st_ok - s1), 32'd4);
    chk("st_mem", 32'(smem[8'h10]), 32'h00A5);
    do_reset();

    // run dropped during ld: ld retires, core idles, then resumes
    clear_mem();
    mem[0]    = enc(3'b000, 1'b1, 3'd3, 9'h020);
    mem[1]    = enc(3'b100, 1'b0, 3'd5, 9'd3);
    mem[2]    = enc(3'b000, 1'b1, 3'd6, 9'd7);
    mem[3]    = enc(3'b001, 1'b0, 3'd0, 9'h1FF);
    mem[8'h20] = 16'h1234;
    push(60, 1, 3'b000, 3, 16'h0020, 0);
    push(61, 2, 3'b000, 5, 16'h1234, 9);
    push(62, 3, 3'b000, 6, 7, 0);
    push(63, 3, 3'b000, -1, 0, 5);
    run = 1'b1;
    k = 0;
    while (!(mem_req && !mem_we && mem_addr == 8'h20) && k < 100) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk("t6_ld_seen", 32'(k < 100), 32'h1);
    run = 1'b0;
    k = 0;
    while (sb.size() > 2 && k < 100) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk("t6_ld_retired", 32'(sb.size()), 32'd2);
    d0  = n_done;
    cnt = 0;
    repeat (8) begin
      @(negedge clk_50MHz);
      if (mem_req) cnt++;
    end
    chk("t6_idle_req", 32'(cnt), 32'd0);
    chk("t6_idle_done", 32'(n_done - d0), 32'd0);
    chk("t6_idle_pc", 32'(pc_out), 32'h2);
    run = 1'b1;
    drain("t6_drain", 300);
    do_reset();

    // Ack withheld: watchdog build halts, default build keeps waiting
    wait_st  = 0;
    clear_mem();
    ack_hold = 1'b1;
    run      = 1'b1;
`ifdef PROC_BUS_TIMEOUT_EN
    cnt = 0;
    k   = 0;
    while (!halted && k < 3 * TO) begin
      if (mem_req) cnt++;
      @(negedge clk_50MHz);
      k++;
    end
    chk("to_halted", 32'(halted), 32'h1);
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_req", 32'(mem_req), 32'h0);
    ack_hold = 1'b0;
    repeat (5) @(negedge clk_50MHz);
    chk("to_stay", 32'(halted), 32'h1);
    chk("to_pc", 32'(pc_out), 32'h0);
`else
    repeat (3 * TO) @(negedge clk_50MHz);
    chk("nto_halted", 32'(halted), 32'h0);
    chk("nto_req", 32'(mem_req), 32'h1);
    chk("nto_pc", 32'(pc_out), 32'h0);
`endif
    do_reset();
    chk("end_halted", 32'(halted), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
